// File: rtl/softmax_exp2_stage.sv
// Softmax exponent stage: splits a non-positive log2-domain score into n.f,
// looks up 2^-f externally, shifts by n and accumulates the per-row sum.
module softmax_exp2_stage #(
  parameter int SUM_W       = 24,
  parameter int N_MAX_SHIFT = 14
) (
  input  logic             I_CLK,
  input  logic             I_RST_N,
  input  logic             I_VALID,
  output logic             O_READY,
  input  logic [19:0]      I_X,
  input  logic             I_LAST,
  output logic [12:0]      O_VI,
  input  logic [15:0]      I_LUT_RES,
  output logic             O_VALID,
  input  logic             I_READY,
  output logic [15:0]      O_EXP,
  output logic             O_LAST,
  output logic [SUM_W-1:0] O_SUM,
  output logic             O_SUM_VALID
);

  localparam logic [SUM_W-1:0] SUM_MAX = {SUM_W{1'b1}};

  logic             v1_q;
  logic             last1_q;
  logic [5:0]       n1_q;
  logic [12:0]      f1_q;
  logic             valid_q;
  logic             last_q;
  logic [15:0]      exp_q;
  logic [SUM_W-1:0] sum_q;
  logic             sum_valid_q;
  logic [SUM_W-1:0] acc_q;

  logic             en_s;
  logic [19:0]      neg_s;
  logic [18:0]      mag_s;
  logic [15:0]      mant_s;
  logic [15:0]      exp_d;
  logic [SUM_W:0]   sum_wide_s;
  logic [SUM_W-1:0] sum_d;

  // Magnitude split, mantissa select/shift and saturating row-sum add.
  always_comb begin
    en_s  = !valid_q || I_READY;
    neg_s = 20'd0 - I_X;
    // Positive scores clamp to x = 0; the most negative code saturates far past the cutoff.
    if (!I_X[19]) begin
      mag_s = 19'd0;
    end else if (neg_s[19]) begin
      mag_s = 19'h7FFFF;
    end else begin
      mag_s = neg_s[18:0];
    end
    mant_s = (f1_q == 13'd0) ? 16'h2000 : I_LUT_RES;
    if (n1_q >= 6'(N_MAX_SHIFT)) begin
      exp_d = 16'd0;
    end else begin
      exp_d = mant_s >> n1_q;
    end
    sum_wide_s = {1'b0, acc_q} + (SUM_W+1)'(exp_d);
    if (sum_wide_s[SUM_W]) begin
      sum_d = SUM_MAX;
    end else begin
      sum_d = sum_wide_s[SUM_W-1:0];
    end
  end

  // Two-stage pipeline with a single global enable; a stall freezes everything.
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      v1_q        <= 1'b0;
      last1_q     <= 1'b0;
      n1_q        <= 6'd0;
      f1_q        <= 13'd0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      exp_q       <= 16'd0;
      sum_q       <= {SUM_W{1'b0}};
      sum_valid_q <= 1'b0;
      acc_q       <= {SUM_W{1'b0}};
    end else if (en_s) begin
      v1_q        <= I_VALID;
      last1_q     <= I_LAST;
      n1_q        <= mag_s[18:13];
      f1_q        <= mag_s[12:0];
      valid_q     <= v1_q;
      last_q      <= v1_q && last1_q;
      sum_valid_q <= v1_q && last1_q;
      if (v1_q) begin
        exp_q <= exp_d;
        // The last beat publishes the total and restarts the row from zero.
        if (last1_q) begin
          sum_q <= sum_d;
          acc_q <= {SUM_W{1'b0}};
        end else begin
          acc_q <= sum_d;
        end
      end
    end
  end

  assign O_READY     = en_s;
  assign O_VI        = f1_q;
  assign O_VALID     = valid_q;
  assign O_EXP       = exp_q;
  assign O_LAST      = last_q;
  assign O_SUM       = sum_q;
  assign O_SUM_VALID = sum_valid_q;

endmodule

// File: tb/tb_softmax_exp2_stage.sv
// Randomised self-checking bench for softmax_exp2_stage with a real-arithmetic
// LUT and a queue-based reference model of beats and row sums.
module tb_softmax_exp2_stage;
  localparam int SUM_W   = 24;
  localparam int SUM_MAX = (1 << SUM_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             i_valid = 1'b0;
  logic             o_ready;
  logic [19:0]      i_x = 20'd0;
  logic             i_last = 1'b0;
  logic [12:0]      o_vi;
  logic [15:0]      lut_res;
  logic             o_valid;
  logic             i_ready = 1'b1;
  logic [15:0]      o_exp;
  logic             o_last;
  logic [SUM_W-1:0] o_sum;
  logic             o_sum_valid;

  softmax_exp2_stage #(.SUM_W(SUM_W), .N_MAX_SHIFT(14)) dut (
    .I_CLK(clk), .I_RST_N(rst_n), .I_VALID(i_valid), .O_READY(o_ready),
    .I_X(i_x), .I_LAST(i_last), .O_VI(o_vi), .I_LUT_RES(lut_res),
    .O_VALID(o_valid), .I_READY(i_ready), .O_EXP(o_exp), .O_LAST(o_last),
    .O_SUM(o_sum), .O_SUM_VALID(o_sum_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    bit last;
    int lit_exp;
    int lit_sum;
  } beat_t;

  beat_t q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    cur_lit_exp = -1;
  int    cur_lit_sum = -1;
  bit    rdy_rand = 1'b0;
  int    msum = 0;
  bit    prev_stall = 1'b0;
  int    p_exp, p_last, p_sum, p_sv, p_vi;

  // Reference 2^-f table, Q2.13 rounded to nearest.
  function automatic int lut_fn(int f);
    real r;
    r = $pow(2.0, -real'(f) / 8192.0) * 8192.0;
    return $rtoi(r + 0.5);
  endfunction

  // 2^x for a Q6.13 score, from the n.f decomposition.
  function automatic int exp_of(int x);
    int m, n, f, mant;
    if (x >= 0) return 8192;
    m    = -x;
    n    = m / 8192;
    f    = m % 8192;
    mant = (f == 0) ? 8192 : lut_fn(f);
    if (n >= 14) return 0;
    return mant >> n;
  endfunction

  assign lut_res = 16'(lut_fn(int'(o_vi)));

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Single compare process: handshake bookkeeping, model comparison, stall stability.
  always @(negedge clk) begin
    beat_t b;
    int    e;
    if (!rst_n) begin
      q.delete();
      msum       = 0;
      prev_stall = 1'b0;
    end else begin
      chk("o_ready", int'(o_ready), int'(!(o_valid && !i_ready)));
      if (prev_stall) begin
        chk("stall_exp", int'(o_exp), p_exp);
        chk("stall_last", int'(o_last), p_last);
        chk("stall_sum", int'(o_sum), p_sum);
        chk("stall_sum_valid", int'(o_sum_valid), p_sv);
        chk("stall_vi", int'(o_vi), p_vi);
      end
      if (o_valid && i_ready) begin
        if (q.size() == 0) begin
          chk("spurious_beat", 1, 0);
        end else begin
          b = q.pop_front();
          e = exp_of(b.x);
          chk("exp", int'(o_exp), e);
          chk("last", int'(o_last), int'(b.last));
          if (b.lit_exp >= 0) chk("exp_literal", int'(o_exp), b.lit_exp);
          msum = msum + e;
          if (msum > SUM_MAX) msum = SUM_MAX;
          if (b.last) begin
            chk("sum", int'(o_sum), msum);
            chk("sum_valid", int'(o_sum_valid), 1);
            if (b.lit_sum >= 0) chk("sum_literal", int'(o_sum), b.lit_sum);
            msum = 0;
          end else begin
            chk("sum_valid_low", int'(o_sum_valid), 0);
          end
        end
      end
      if (i_valid && o_ready) begin
        b.x       = int'($signed(i_x));
        b.last    = i_last;
        b.lit_exp = cur_lit_exp;
        b.lit_sum = cur_lit_sum;
        q.push_back(b);
      end
      prev_stall = o_valid && !i_ready;
      p_exp  = int'(o_exp);
      p_last = int'(o_last);
      p_sum  = int'(o_sum);
      p_sv   = int'(o_sum_valid);
      p_vi   = int'(o_vi);
    end
  end

  // Downstream ready: constant high or random backpressure.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      i_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send(int x, bit last, int le, int ls);
    int guard;
    i_valid     = 1'b1;
    i_x         = 20'(x);
    i_last      = last;
    cur_lit_exp = le;
    cur_lit_sum = ls;
    guard = 0;
    @(negedge clk);
    while (!o_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    i_valid     = 1'b0;
    i_last      = 1'b0;
    cur_lit_exp = -1;
    cur_lit_sum = -1;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((q.size() != 0 || o_valid) && guard < 500) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 500) chk("drain_timeout", 0, 1);
  endtask

  task automatic check_reset_outputs();
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_exp", int'(o_exp), 0);
    chk("rst_last", int'(o_last), 0);
    chk("rst_sum", int'(o_sum), 0);
    chk("rst_sum_valid", int'(o_sum_valid), 0);
    chk("rst_vi", int'(o_vi), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int x;
    bit l;
    #12;
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Pin the reference model against hand-computed values.
    chk("model_x0", exp_of(0), 'h2000);
    chk("model_m1", exp_of(-8192), 'h1000);
    chk("model_mhalf", exp_of(-4096), 'h16A1);
    chk("model_m2p5", exp_of(-20480), 'h05A8);
    chk("model_m14", exp_of(-14 * 8192), 0);
    chk("model_pos", exp_of(500), 'h2000);
    chk("model_m13", exp_of(-13 * 8192), 1);

    // Directed single-beat rows covering pass-through, fraction path and limits.
    send(0, 1'b1, 'h2000, 'h2000);
    send(-8192, 1'b1, 'h1000, 'h1000);
    send(-4096, 1'b1, 'h16A1, 'h16A1);
    send(-20480, 1'b1, 'h05A8, 'h05A8);
    send(-14 * 8192, 1'b1, 0, 0);
    send(500, 1'b1, 'h2000, 'h2000);
    send(-13 * 8192, 1'b1, 1, 1);
    // Four-beat row followed immediately by a new row.
    send(0, 1'b0, 'h2000, -1);
    send(-8192, 1'b0, 'h1000, -1);
    send(-16384, 1'b0, 'h0800, -1);
    send(-24576, 1'b1, 'h0400, 'h3C00);
    send(-8192, 1'b1, 'h1000, 'h1000);
    drain();

    // Eight beats under random backpressure.
    rdy_rand = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(-int'($urandom_range(0, 5 * 8192)), (i == 7), -1, -1);
    end
    drain();

    // Reset with two beats of a row in flight.
    rdy_rand = 1'b0;
    @(posedge clk);
    #1;
    send(-8192, 1'b0, -1, -1);
    send(-4096, 1'b0, -1, -1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(-8192, 1'b1, 'h1000, 'h1000);
    drain();

    // Long random stream with gaps, random row boundaries and backpressure.
    rdy_rand = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      if ($urandom_range(0, 9) == 0) x = int'($urandom_range(0, 1000));
      else x = -int'($urandom_range(0, 16 * 8192));
      l = (i == 199) || ($urandom_range(0, 3) == 0);
      send(x, l, -1, -1);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/softmax_exp2_stage.md
Name: softmax_exp2_stage

Overview:
- Streaming exponent stage of the softmax datapath. Sits directly upstream of the negative-range 2^x LUT and consumes that LUT's result.
- Takes max-subtracted, log2e-scaled scores x ≤ 0 and splits each into an integer part n and a fractional part f. It drives f to the LUT, then right-shifts the LUT mantissa by n to form 2^x.
- Also accumulates the per-row sum of exponents for the downstream normaliser.

Parameters:
- SUM_W, 24, width of the row-sum accumulator (Q(SUM_W-13).13 unsigned).
- N_MAX_SHIFT, 14, shift amount at or above which the exponent is forced to 0.

Ports:
- I_CLK  in  1  clock
- I_RST_N  in  1  asynchronous active-low reset
- I_VALID  in  1  input beat valid
- O_READY  out  1  stage can accept a beat
- I_X  in  20  signed Q6.13 scaled score, expected ≤ 0
- I_LAST  in  1  final element of a row
- O_VI  out  13  fraction magnitude driven to the LUT
- I_LUT_RES  in  16  LUT result for O_VI, Q2.13 (0x2000 = 1.0)
- O_VALID  out  1  output beat valid
- I_READY  in  1  downstream accepts the beat
- O_EXP  out  16  2^x, unsigned Q2.13
- O_LAST  out  1  I_LAST delayed with the beat
- O_SUM  out  SUM_W  row sum, including the O_LAST beat
- O_SUM_VALID  out  1  O_SUM is valid; asserted with the O_LAST beat

Behaviour:
- One clock, I_CLK. Reset is asynchronous and active-low on I_RST_N.
- Reset values: O_VALID=0, O_EXP=0, O_LAST=0, O_SUM=0, O_SUM_VALID=0, internal stage-1 valid=0, accumulator=0, O_VI=0.
- Pipeline: two register stages with a global enable, en = !O_VALID || I_READY. O_READY = en.
- A beat is accepted when I_VALID && O_READY. Latency from acceptance to O_VALID is 2 cycles with no stall, giving throughput of 1 beat/cycle.
- Stage 1, on en, captures:
  - m = -I_X as 19-bit unsigned magnitude; if I_X > 0, m = 0 (clamp to x = 0).
  - n = m[18:13], f = m[12:0], plus valid and last.
- O_VI = registered f, driven from the stage-1 register. The LUT is combinational between stage 1 and stage 2.
- Stage 2, on en, computes:
  - mant = (f == 0) ? 0x2000 : I_LUT_RES. The LUT output is ignored when f == 0.
  - O_EXP = (n ≥ N_MAX_SHIFT) ? 0 : mant >> n, logical shift with truncation.
- Bubbles: when stage 1 is invalid, stage 2 loads O_VALID=0. The accumulator is unchanged and O_SUM_VALID=0.
- Stall (O_VALID && !I_READY): all registers hold. O_EXP, O_LAST, O_SUM and O_SUM_VALID stay stable. O_VI stays stable.
- Accumulator:
  - On a stage-2 load of a valid beat, sum_next = acc + exp_new, saturating at 2^SUM_W-1.
  - Non-last beat: acc ← sum_next.
  - Last beat: O_SUM ← sum_next, O_SUM_VALID ← 1, acc ← 0.
  - O_SUM_VALID clears on the next stage-2 load.
- Rows of length 1 are legal: O_SUM equals that beat's O_EXP.
- Back-to-back rows need no gap. The first beat of a new row accumulates from 0 in the same cycle the previous last beat is presented.
- Reset mid-row or mid-stall: in-flight beats are discarded, the accumulator is cleared, and outputs return to their reset values immediately (asynchronous assert).

Test Plan:
- Pass-through:
  - I_X=0 → O_EXP=0x2000 after 2 cycles.
  - I_X=-8192 (-1.0) → n=1, f=0, O_EXP=0x1000. I_LUT_RES is not used.
- Fraction path: LUT model returns 0x16A1 for f=4096.
  - I_X=-4096 → O_VI=4096, O_EXP=0x16A1.
  - I_X=-20480 (-2.5) → n=2, O_EXP=0x05A8.
- Limits:
  - I_X=-(14·8192) → O_EXP=0.
  - I_X=+500 → clamped, O_EXP=0x2000.
  - I_X=-(13·8192) → O_EXP=0x0001.
- Row sum: 4 beats of -0, -1.0, -2.0, -3.0 with the last beat flagged → O_EXP 0x2000, 0x1000, 0x0800, 0x0400; O_SUM=0x3C00 with O_SUM_VALID on the 4th beat. A following row starts from 0.
- Backpressure:
  - Stream 8 beats with I_READY toggling randomly. No beat is lost or duplicated, outputs are stable while stalled, O_READY=0 exactly when O_VALID && !I_READY, and the sum is correct.
- Reset: assert I_RST_N=0 after 2 beats of a row are in flight → outputs are 0 at once. The next row's O_SUM excludes the discarded beats.
